prog_rom_loader: RTL and testbench

- Program-memory writer/server for the microprocessor core.
- Receives instruction words over a byte-serial valid/ready load stream and writes them into an internal instruction store.
- Holds the core in reset while loading, then releases it.
- Once released, answers the core's ROM_readEnable/ROM_address fetches with registered ROM_data, acting as the memory end of the core's instruction-fetch interface.

---
 rtl/prog_rom_loader.sv | 203 ++++++++++++++++++++
 tb/tb_prog_rom_loader.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_rom_loader.sv
// prog_rom_loader: program-memory writer and server for the microprocessor core.
// Instruction words arrive as byte pairs (low byte, then high byte) over a
// valid/ready stream and are written into an internal instruction store while
// the core is held in reset. After the last word the core is released and its
// ROM_readEnable/ROM_address fetches are answered with registered ROM_data.
// Optional feature macro: PROG_CHECKSUM_EN adds a trailing mod-256 checksum
// byte that must match before the core is released.

module prog_rom_loader #(
  parameter int ROM_addressBits = 6,
  parameter int RF_addressBits  = 3
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_load_start,
  input  logic [ROM_addressBits:0]        i_load_len,
  input  logic                            i_in_valid,
  input  logic [7:0]                      i_in_data,
  output logic                            o_in_ready,
  output logic                            o_cpu_rst_n,
  output logic                            o_load_done,
  output logic                            o_load_error,
  input  logic                            i_ROM_readEnable,
  input  logic [ROM_addressBits-1:0]      i_ROM_address,
  output logic [4+2*RF_addressBits-1:0]   o_ROM_data
);

  localparam int INSTR_W = 4 + 2 * RF_addressBits;
  localparam int DEPTH   = 2 ** ROM_addressBits;
  localparam int LENW    = ROM_addressBits + 1;
  localparam logic [LENW-1:0] C_DEPTH = LENW'(DEPTH);
  localparam logic [LENW-1:0] C_ONE   = LENW'(1);

`ifdef PROG_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_LO = 3'd1,
    LOAD_HI = 3'd2,
    LOAD_CK = 3'd3,
    RUN     = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_LO = 3'd1,
    LOAD_HI = 3'd2,
    RUN     = 3'd4
  } state_t;
`endif

  state_t                r_state;
  state_t                w_stateNext;

  logic [INSTR_W-1:0]    r_mem [DEPTH];
  logic [ROM_addressBits-1:0] r_wrAddr;
  logic [LENW-1:0]       r_remaining;
  logic [LENW-1:0]       r_loadedLen;
  logic [7:0]            r_lo;
  logic                  r_loadError;
  logic [INSTR_W-1:0]    r_romData;
`ifdef PROG_CHECKSUM_EN
  logic [7:0]            r_sum;
`endif

  logic                  w_xfer;
  logic                  w_startOk;
  logic                  w_lastWord;
  logic [INSTR_W-1:0]    w_word;

  // A start is only honoured when the requested length fits the store.
  assign w_startOk  = i_load_start && (i_load_len != '0) && (i_load_len <= C_DEPTH);
  assign w_xfer     = i_in_valid && o_in_ready;
  assign w_lastWord = (r_remaining == C_ONE);
  assign w_word     = {i_in_data[INSTR_W-9:0], r_lo};

`ifdef PROG_CHECKSUM_EN
  assign o_in_ready = (r_state == LOAD_LO) || (r_state == LOAD_HI) || (r_state == LOAD_CK);
`else
  assign o_in_ready = (r_state == LOAD_LO) || (r_state == LOAD_HI);
`endif
  assign o_cpu_rst_n  = (r_state == RUN);
  assign o_load_done  = (r_state == RUN);
  assign o_load_error = r_loadError;
  assign o_ROM_data   = r_romData;

  // State register; reset aborts any load in progress back to IDLE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state decode: byte pairs alternate LO/HI until the last word lands.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE: begin
        if (w_startOk) w_stateNext = LOAD_LO;
      end
      LOAD_LO: begin
        if (w_xfer) w_stateNext = LOAD_HI;
      end
      LOAD_HI: begin
        if (w_xfer) begin
`ifdef PROG_CHECKSUM_EN
          w_stateNext = w_lastWord ? LOAD_CK : LOAD_LO;
`else
          w_stateNext = w_lastWord ? RUN : LOAD_LO;
`endif
        end
      end
`ifdef PROG_CHECKSUM_EN
      LOAD_CK: begin
        if (w_xfer) w_stateNext = (i_in_data == r_sum) ? RUN : IDLE;
      end
`endif
      RUN: begin
        if (w_startOk) w_stateNext = LOAD_LO;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // Load bookkeeping, sticky error flag and the registered fetch port.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wrAddr    <= '0;
      r_remaining <= '0;
      r_loadedLen <= '0;
      r_lo        <= '0;
      r_loadError <= 1'b0;
      r_romData   <= '0;
`ifdef PROG_CHECKSUM_EN
      r_sum       <= '0;
`endif
    end else begin
      case (r_state)
        IDLE, RUN: begin
          if (i_load_start) begin
            if (w_startOk) begin
              r_wrAddr    <= '0;
              r_remaining <= i_load_len;
              r_loadError <= 1'b0;
`ifdef PROG_CHECKSUM_EN
              r_sum       <= '0;
`endif
            end else begin
              r_loadError <= 1'b1;
            end
          end
        end
        LOAD_LO: begin
          if (w_xfer) begin
            r_lo <= i_in_data;
`ifdef PROG_CHECKSUM_EN
            r_sum <= r_sum + i_in_data;
`endif
          end
        end
        LOAD_HI: begin
          if (w_xfer) begin
`ifdef PROG_CHECKSUM_EN
            r_sum <= r_sum + i_in_data;
`endif
            if (w_lastWord) begin
              r_loadedLen <= {1'b0, r_wrAddr} + C_ONE;
            end else begin
              r_wrAddr    <= r_wrAddr + 1'b1;
              r_remaining <= r_remaining - C_ONE;
            end
          end
        end
`ifdef PROG_CHECKSUM_EN
        LOAD_CK: begin
          if (w_xfer && (i_in_data != r_sum)) begin
            r_loadError <= 1'b1;
            r_loadedLen <= '0;
          end
        end
`endif
        default: ;
      endcase

      if ((r_state == RUN) && i_ROM_readEnable) begin
        if ({1'b0, i_ROM_address} < r_loadedLen) begin
          r_romData <= r_mem[i_ROM_address];
        end else begin
          r_romData <= '0;
        end
      end
    end
  end

  // Instruction store write port; contents deliberately survive reset.
  always_ff @(posedge i_clk) begin
    if ((r_state == LOAD_HI) && w_xfer) begin
      r_mem[r_wrAddr] <= w_word;
    end
  end

endmodule

// File: tb/tb_prog_rom_loader.sv
// tb_prog_rom_loader: directed bench for prog_rom_loader with default
// parameters (64-word store, 10-bit instructions). Honours PROG_CHECKSUM_EN
// by appending the checksum byte to every load when the macro is defined.

module tb_prog_rom_loader;

  localparam int AW = 6;
  localparam int IW = 10;
`ifdef PROG_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          loadStart;
  logic [AW:0]   loadLen;
  logic          inValid;
  logic [7:0]    inData;
  logic          inReady;
  logic          cpuRstN;
  logic          loadDone;
  logic          loadError;
  logic          romReadEnable;
  logic [AW-1:0] romAddress;
  logic [IW-1:0] romData;

  int            checkCount = 0;
  int            errorCount = 0;
  int            cycleCount = 0;
  int            startCycle;
  logic [7:0]    tbSum;

  prog_rom_loader #(
    .ROM_addressBits(AW),
    .RF_addressBits (3)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_load_start    (loadStart),
    .i_load_len      (loadLen),
    .i_in_valid      (inValid),
    .i_in_data       (inData),
    .o_in_ready      (inReady),
    .o_cpu_rst_n     (cpuRstN),
    .o_load_done     (loadDone),
    .o_load_error    (loadError),
    .i_ROM_readEnable(romReadEnable),
    .i_ROM_address   (romAddress),
    .o_ROM_data      (romData)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle counter used to measure load duration.
  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Hard stop in case something wedges outside a bounded wait.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic startLoad(input int len);
    @(negedge clk);
    loadStart = 1'b1;
    loadLen   = (AW+1)'(len);
    tbSum     = 8'h00;
    @(negedge clk);
    loadStart = 1'b0;
  endtask

  // Offers one byte, optionally preceded by idle cycles carrying junk data.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    int t;
    for (int g = 0; g < gap; g++) begin
      inValid = 1'b0;
      inData  = 8'hAA;
      @(negedge clk);
    end
    inValid = 1'b1;
    inData  = b;
    t = 0;
    while (!inReady && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!inReady) begin
      checkOutput("xferReady", {31'd0, inReady}, 32'd1);
    end else begin
      tbSum = tbSum + b;
      @(negedge clk);
    end
  endtask

  task automatic finishLoad(input int gap);
`ifdef PROG_CHECKSUM_EN
    applyStimulus(tbSum, gap);
`endif
    inValid = 1'b0;
    inData  = 8'h00;
  endtask

  task automatic readRom(input int addr, input logic [IW-1:0] exp, input string tag);
    @(negedge clk);
    romReadEnable = 1'b1;
    romAddress    = AW'(addr);
    @(negedge clk);
    romReadEnable = 1'b0;
    checkOutput(tag, 32'(romData), 32'(exp));
  endtask

  task automatic loadThree(input int gap);
    applyStimulus(8'h34, gap);
    applyStimulus(8'h02, gap);
    applyStimulus(8'hFF, gap);
    applyStimulus(8'h03, gap);
    applyStimulus(8'h01, gap);
    applyStimulus(8'hFC, gap);
    finishLoad(gap);
  endtask

  initial begin
    rst = 1'b1; loadStart = 1'b0; loadLen = '0; inValid = 1'b0; inData = 8'h00;
    romReadEnable = 1'b0; romAddress = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("rstCpuRstN", {31'd0, cpuRstN}, 32'd0);
    checkOutput("rstInReady", {31'd0, inReady}, 32'd0);
    checkOutput("rstLoadDone", {31'd0, loadDone}, 32'd0);
    checkOutput("rstRomData", 32'(romData), 32'd0);

    // Three words, valid held high.
    startLoad(3);
    startCycle = cycleCount;
    checkOutput("loadingReady", {31'd0, inReady}, 32'd1);
    checkOutput("loadingCpuRstN", {31'd0, cpuRstN}, 32'd0);
    loadThree(0);
    checkOutput("loadCycles", 32'(cycleCount - startCycle), 32'(6 + CK));
    checkOutput("runCpuRstN", {31'd0, cpuRstN}, 32'd1);
    checkOutput("runLoadDone", {31'd0, loadDone}, 32'd1);
    checkOutput("runInReady", {31'd0, inReady}, 32'd0);
    checkOutput("runLoadError", {31'd0, loadError}, 32'd0);
    readRom(0, 10'h234, "rdA0");
    @(negedge clk);
    romAddress = 6'd1;
    @(negedge clk);
    checkOutput("rdHold", 32'(romData), 32'h234);
    readRom(1, 10'h3FF, "rdA1");
    readRom(2, 10'h001, "rdA2");
    readRom(5, 10'h000, "rdA5");

    // Same load from RUN with valid toggling and junk data in the gaps.
    startLoad(3);
    checkOutput("reloadCpuRstN", {31'd0, cpuRstN}, 32'd0);
    loadThree(1);
    checkOutput("toggleRun", {31'd0, loadDone}, 32'd1);
    readRom(0, 10'h234, "tglA0");
    readRom(1, 10'h3FF, "tglA1");
    readRom(2, 10'h001, "tglA2");

    // Rejected start while running leaves the core running.
    startLoad(0);
    checkOutput("rejRunDone", {31'd0, loadDone}, 32'd1);
    checkOutput("rejRunError", {31'd0, loadError}, 32'd1);
    readRom(1, 10'h3FF, "rejRunRead");

    // Rejected lengths from IDLE, then a valid one clears the error.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checkOutput("rstClrError", {31'd0, loadError}, 32'd0);
    startLoad(0);
    checkOutput("len0Error", {31'd0, loadError}, 32'd1);
    checkOutput("len0Idle", {31'd0, inReady}, 32'd0);
    startLoad(65);
    checkOutput("len65Error", {31'd0, loadError}, 32'd1);
    checkOutput("len65Idle", {31'd0, inReady}, 32'd0);
    startLoad(1);
    checkOutput("len1ClrError", {31'd0, loadError}, 32'd0);
    checkOutput("len1Ready", {31'd0, inReady}, 32'd1);
    applyStimulus(8'h55, 0);
    applyStimulus(8'h01, 0);
    finishLoad(0);
    readRom(0, 10'h155, "len1A0");

    // Reset in the middle of a four-word load.
    startLoad(4);
    applyStimulus(8'h11, 0);
    applyStimulus(8'h02, 0);
    applyStimulus(8'h22, 0);
    inValid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midRstCpuRstN", {31'd0, cpuRstN}, 32'd0);
    checkOutput("midRstReady", {31'd0, inReady}, 32'd0);
    checkOutput("midRstRomData", 32'(romData), 32'd0);
    startLoad(1);
    applyStimulus(8'h78, 0);
    applyStimulus(8'h03, 0);
    finishLoad(0);
    checkOutput("freshRun", {31'd0, cpuRstN}, 32'd1);
    readRom(0, 10'h378, "freshA0");
    readRom(1, 10'h000, "freshA1");

    // Full-depth load: word i = {i[1:0], i*3}.
    startLoad(64);
    for (int i = 0; i < 64; i++) begin
      applyStimulus(8'(i * 3), 0);
      applyStimulus(8'(i), 0);
    end
    finishLoad(0);
    checkOutput("fullRun", {31'd0, loadDone}, 32'd1);
    readRom(0, 10'h000, "fullA0");
    readRom(40, {2'(40), 8'(120)}, "fullA40");
    readRom(63, {2'(63), 8'(189)}, "fullA63");

`ifdef PROG_CHECKSUM_EN
    // Checksum match and mismatch.
    startLoad(1);
    applyStimulus(8'h10, 0);
    applyStimulus(8'h01, 0);
    applyStimulus(8'h11, 0);
    inValid = 1'b0;
    checkOutput("ckGoodRun", {31'd0, cpuRstN}, 32'd1);
    readRom(0, 10'h110, "ckGoodA0");
    startLoad(1);
    applyStimulus(8'h10, 0);
    applyStimulus(8'h01, 0);
    applyStimulus(8'h12, 0);
    inValid = 1'b0;
    checkOutput("ckBadError", {31'd0, loadError}, 32'd1);
    checkOutput("ckBadCpuRstN", {31'd0, cpuRstN}, 32'd0);
    checkOutput("ckBadReady", {31'd0, inReady}, 32'd0);
    @(negedge clk);
    checkOutput("ckBadStay", {31'd0, cpuRstN}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
